uart_cmd_responder: RTL and testbench
=====================================

UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum accepted payload length in bytes.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 208320, the inter-byte timeout in clk cycles (20 bit times at 9600 baud, 100 MHz).
REQ-003 SHALL have port clk, input, 1 bit: the 100 MHz clock.
REQ-004 SHALL have port reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 SHALL have port rx_done, input, 1 bit: one-cycle pulse; rx_byte is valid while it is high.
REQ-006 SHALL have port rx_byte, input, 8 bits: the received byte.
REQ-007 SHALL have port tx_ready, input, 1 bit: high when the transmitter is idle; it drops the cycle after tx_send.
REQ-008 SHALL have port tx_send, output, 1 bit: one-cycle send strobe to the transmitter.
REQ-009 SHALL have port tx_data, output, 8 bits: the byte to send, valid in the tx_send cycle.
REQ-010 SHALL have port busy, output, 1 bit: high in any state other than WAIT_SOF.
REQ-011 SHALL have port frame_ok, output, 1 bit: one-cycle pulse when a valid frame is accepted.
REQ-012 SHALL have port err_count, output, 8 bits: saturating count of errors.

Function
REQ-013 SHALL use this request frame: 0xA5, CMD, LEN, LEN payload bytes, CHK; CHK = XOR of CMD, LEN and all payload bytes.
REQ-014 SHALL use a reply frame of the same format, with the reply CHK computed over the reply's CMD, LEN and payload.
REQ-015 SHALL have receive states WAIT_SOF, GET_CMD, GET_LEN, GET_DATA and GET_CHK, each advancing only on rx_done.
REQ-016 SHALL, in WAIT_SOF, ignore every byte except 0xA5.
REQ-017 SHALL, in GET_LEN, skip to GET_CHK when LEN = 0.
REQ-018 SHALL, in GET_LEN, build a NAK with code 0x02 when LEN > MAX_LEN, without receiving payload or CHK.
REQ-019 SHALL store payload bytes in a MAX_LEN x 8 buffer at index 0..LEN-1.
REQ-020 SHALL, on a CHK mismatch, build a NAK with code 0x01.
REQ-021 SHALL, on a good CHK with CMD 0x01 (PING), reply 0x81 with LEN 0.
REQ-022 SHALL, on a good CHK with CMD 0x02 (ECHO), reply 0x82 with the same LEN and payload.
REQ-023 SHALL, on a good CHK with CMD 0x03 (STATUS), reply 0x83 with LEN 2 and payload {frame_cnt, err_count}, sampled before this frame is counted.
REQ-024 SHALL, on a good CHK with any other CMD, build a NAK with code 0x03.
REQ-025 SHALL format every NAK as 0xA5, 0xFF, 0x01, code, CHK.
REQ-026 SHALL increment the internal 8-bit wrapping frame_cnt and pulse frame_ok for each of cases 0x01, 0x02 and 0x03.
REQ-027 SHALL increment err_count, saturating at 0xFF, on every NAK, every timeout and every overrun.
REQ-028 SHALL have transmit states SEND, WAIT_LO and WAIT_HI, sequenced as follows:
- SEND: when tx_ready = 1, assert tx_send for exactly one cycle with the next reply byte and go to WAIT_LO.
- WAIT_LO: wait for tx_ready = 0, then go to WAIT_HI.
- WAIT_HI: wait for tx_ready = 1; after the last byte go to WAIT_SOF, otherwise return to SEND.
REQ-029 SHALL never assert tx_send while tx_ready = 0.
REQ-030 SHALL hold tx_data stable from the tx_send cycle until the next tx_send.
REQ-031 SHALL drop an rx_done arriving during SEND, WAIT_LO or WAIT_HI and count it as an overrun error.
REQ-032 SHALL reset a timeout counter on every rx_done in GET_CMD to GET_CHK.
REQ-033 SHALL, when the timeout counter reaches TIMEOUT_CYC-1, return to WAIT_SOF, count an error and send no reply.
REQ-034 SHALL take the first reply byte in SEND no earlier than the cycle after the final request byte's rx_done.
REQ-035 SHALL give an error event priority over frame_ok when both occur in the same cycle.

Reset
REQ-036 SHALL, on reset assertion, immediately set the state to WAIT_SOF, tx_send=0, tx_data=0x00, busy=0, frame_ok=0, err_count=0, frame_cnt=0 and the timeout counter to 0.
REQ-037 SHALL, when reset arrives mid-frame or mid-reply, abandon the frame or reply with no further tx_send.
REQ-038 SHALL leave the payload buffer contents don't-care after reset.

Structure
REQ-039 SHALL place SOF 0xA5, the command codes 0x01/0x02/0x03, the reply codes 0x81/0x82/0x83/0xFF, the NAK codes 0x01/0x02/0x03 and the state encodings in a shared package, uart_cmd_pkg.
REQ-040 SHALL place reply byte sequencing, covering the byte index and the handshake states, in the sub-module uart_reply_seq.

Verification
REQ-041 SHALL cover PING: A5 01 00 01 -> tx bytes A5 81 00 81, frame_ok pulses once, err_count=0.
REQ-042 SHALL cover ECHO: A5 02 02 11 22 33 -> tx bytes A5 82 02 11 22 B3.
REQ-043 SHALL cover a bad checksum: A5 01 00 00 -> tx bytes A5 FF 01 01 FF, err_count=1.
REQ-044 SHALL cover an unknown command and an oversize LEN: A5 07 00 07 -> A5 FF 01 03 FD; A5 01 20 -> A5 FF 01 02 FC immediately after LEN.
REQ-045 SHALL cover STATUS after one PING and one error: A5 03 00 03 -> A5 83 02 01 01 81.
REQ-046 SHALL cover timeout and reset: A5 01, then idle for TIMEOUT_CYC cycles -> no tx_send, err_count+1, busy=0; reset asserted mid-reply -> tx_send stays 0 and all outputs return to reset values.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encodings and helpers for the UART command responder.
package uart_cmd_pkg;

  localparam logic [7:0] SOF        = 8'hA5;
  localparam logic [7:0] CMD_PING   = 8'h01;
  localparam logic [7:0] CMD_ECHO   = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] REP_PING   = 8'h81;
  localparam logic [7:0] REP_ECHO   = 8'h82;
  localparam logic [7:0] REP_STATUS = 8'h83;
  localparam logic [7:0] REP_NAK    = 8'hFF;
  localparam logic [7:0] NAK_CHK    = 8'h01;
  localparam logic [7:0] NAK_LEN    = 8'h02;
  localparam logic [7:0] NAK_CMD    = 8'h03;

  typedef enum logic [2:0] {
    WAIT_SOF,
    GET_CMD,
    GET_LEN,
    GET_DATA,
    GET_CHK,
    REPLY
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    SEND,
    WAIT_LO,
    WAIT_HI
  } tx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_reply_seq.sv
// Walks the reply frame byte by byte, handshaking each byte with the UART transmitter.
module uart_reply_seq
  import uart_cmd_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] last_idx_i,
  input  logic [7:0] byte_i,
  input  logic       tx_ready_i,
  output logic [7:0] idx_o,
  output logic       tx_send_o,
  output logic [7:0] tx_data_o,
  output logic       done_o
);

  tx_state_e  state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic       send_q, send_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= TX_IDLE;
      idx_q   <= 8'd0;
      send_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      send_q  <= send_d;
      data_q  <= data_d;
    end
  end

  // tx_send is registered, so it is seen in the first WAIT_LO cycle while tx_ready is still high
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    send_d  = 1'b0;
    data_d  = data_q;
    done_o  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (start_i) begin
          idx_d   = 8'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready_i) begin
          send_d  = 1'b1;
          data_d  = byte_i;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_ready_i) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_ready_i) begin
          if (idx_q == last_idx_i) begin
            done_o  = 1'b1;
            state_d = TX_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign idx_o     = idx_q;
  assign tx_send_o = send_q;
  assign tx_data_o = data_q;

endmodule

// File: rtl/uart_cmd_responder.sv
// Framed UART command parser (PING/ECHO/STATUS) that builds and sends replies or NAKs.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 208320
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_byte,
  input  logic       tx_ready,
  output logic       tx_send,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       frame_ok,
  output logic [7:0] err_count
);

  localparam int              IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int              TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      MAX_LEN8 = 8'(MAX_LEN);

  rx_state_e     state_q, state_d;
  logic [7:0]    cmd_q, cmd_d, len_q, len_d, cnt_q, cnt_d, x_q, x_d;
  logic [7:0]    err_q, err_d, fcnt_q, fcnt_d;
  logic [TW-1:0] to_q, to_d;
  logic          fok_q, fok_d;
  logic [7:0]    rep_cmd_q, rep_cmd_d, rep_len_q, rep_len_d, rep_chk_q, rep_chk_d;
  logic [7:0]    rep_p0_q, rep_p0_d, rep_p1_q, rep_p1_d;
  logic          rep_echo_q, rep_echo_d;
  logic          buf_we, start, nak, good, err_ev, in_rx;
  logic [7:0]    nak_code;
  logic          seq_done;
  logic [7:0]    seq_idx, tx_byte, last_idx;
  logic [IW-1:0] pidx;
  logic [7:0]    buf_q [MAX_LEN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_SOF;
      cmd_q      <= 8'h00;
      len_q      <= 8'h00;
      cnt_q      <= 8'h00;
      x_q        <= 8'h00;
      err_q      <= 8'h00;
      fcnt_q     <= 8'h00;
      to_q       <= '0;
      fok_q      <= 1'b0;
      rep_cmd_q  <= 8'h00;
      rep_len_q  <= 8'h00;
      rep_chk_q  <= 8'h00;
      rep_p0_q   <= 8'h00;
      rep_p1_q   <= 8'h00;
      rep_echo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      err_q      <= err_d;
      fcnt_q     <= fcnt_d;
      to_q       <= to_d;
      fok_q      <= fok_d;
      rep_cmd_q  <= rep_cmd_d;
      rep_len_q  <= rep_len_d;
      rep_chk_q  <= rep_chk_d;
      rep_p0_q   <= rep_p0_d;
      rep_p1_q   <= rep_p1_d;
      rep_echo_q <= rep_echo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[cnt_q[IW-1:0]] <= rx_byte;
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    err_d      = err_q;
    fcnt_d     = fcnt_q;
    fok_d      = 1'b0;
    rep_cmd_d  = rep_cmd_q;
    rep_len_d  = rep_len_q;
    rep_chk_d  = rep_chk_q;
    rep_p0_d   = rep_p0_q;
    rep_p1_d   = rep_p1_q;
    rep_echo_d = rep_echo_q;
    buf_we     = 1'b0;
    nak        = 1'b0;
    nak_code   = 8'h00;
    good       = 1'b0;
    err_ev     = 1'b0;
    in_rx      = (state_q inside {GET_CMD, GET_LEN, GET_DATA, GET_CHK});
    to_d       = in_rx ? to_q + TW'(1) : '0;

    case (state_q)
      WAIT_SOF: begin
        if (rx_done && rx_byte == SOF) state_d = GET_CMD;
      end
      GET_CMD: begin
        if (rx_done) begin
          cmd_d   = rx_byte;
          x_d     = rx_byte;
          to_d    = '0;
          state_d = GET_LEN;
        end
      end
      GET_LEN: begin
        if (rx_done) begin
          len_d = rx_byte;
          x_d   = x_q ^ rx_byte;
          cnt_d = 8'd0;
          to_d  = '0;
          if (rx_byte > MAX_LEN8) begin
            nak      = 1'b1;
            nak_code = NAK_LEN;
          end else if (rx_byte == 8'd0) begin
            state_d = GET_CHK;
          end else begin
            state_d = GET_DATA;
          end
        end
      end
      GET_DATA: begin
        if (rx_done) begin
          buf_we = 1'b1;
          x_d    = x_q ^ rx_byte;
          cnt_d  = cnt_q + 8'd1;
          to_d   = '0;
          if (cnt_q == len_q - 8'd1) state_d = GET_CHK;
        end
      end
      GET_CHK: begin
        if (rx_done) begin
          to_d = '0;
          if (rx_byte != x_q) begin
            nak      = 1'b1;
            nak_code = NAK_CHK;
          end else begin
            rep_echo_d = 1'b0;
            case (cmd_q)
              CMD_PING: begin
                good      = 1'b1;
                rep_cmd_d = REP_PING;
                rep_len_d = 8'd0;
                rep_chk_d = REP_PING;
              end
              CMD_ECHO: begin
                good       = 1'b1;
                rep_cmd_d  = REP_ECHO;
                rep_len_d  = len_q;
                rep_echo_d = 1'b1;
                // Same LEN and payload, so only the command byte changes in the XOR
                rep_chk_d  = x_q ^ CMD_ECHO ^ REP_ECHO;
              end
              CMD_STATUS: begin
                good      = 1'b1;
                rep_cmd_d = REP_STATUS;
                rep_len_d = 8'd2;
                rep_p0_d  = fcnt_q;
                rep_p1_d  = err_q;
                rep_chk_d = REP_STATUS ^ 8'd2 ^ fcnt_q ^ err_q;
              end
              default: begin
                nak      = 1'b1;
                nak_code = NAK_CMD;
              end
            endcase
          end
        end
      end
      REPLY: begin
        if (rx_done) err_ev = 1'b1;
        if (seq_done) state_d = WAIT_SOF;
      end
      default: state_d = WAIT_SOF;
    endcase

    // A timeout wins over whatever the final byte would have produced
    if (in_rx && to_q == TO_LAST) begin
      nak     = 1'b0;
      good    = 1'b0;
      err_ev  = 1'b1;
      to_d    = '0;
      state_d = WAIT_SOF;
    end

    if (nak) begin
      rep_cmd_d  = REP_NAK;
      rep_len_d  = 8'd1;
      rep_p0_d   = nak_code;
      rep_chk_d  = REP_NAK ^ 8'd1 ^ nak_code;
      rep_echo_d = 1'b0;
      err_ev     = 1'b1;
      state_d    = REPLY;
    end

    if (good) begin
      fcnt_d  = fcnt_q + 8'd1;
      fok_d   = 1'b1;
      state_d = REPLY;
    end

    if (err_ev) err_d = sat_inc8(err_q);
  end

  assign start    = nak | good;
  assign last_idx = rep_len_q + 8'd3;

  always_comb begin
    tx_byte = 8'h00;
    pidx    = IW'(seq_idx - 8'd3);
    if (seq_idx == 8'd0)           tx_byte = SOF;
    else if (seq_idx == 8'd1)      tx_byte = rep_cmd_q;
    else if (seq_idx == 8'd2)      tx_byte = rep_len_q;
    else if (seq_idx == last_idx)  tx_byte = rep_chk_q;
    else if (rep_echo_q)           tx_byte = buf_q[pidx];
    else if (seq_idx == 8'd3)      tx_byte = rep_p0_q;
    else                           tx_byte = rep_p1_q;
  end

  uart_reply_seq u_reply_seq (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .last_idx_i (last_idx),
    .byte_i     (tx_byte),
    .tx_ready_i (tx_ready),
    .idx_o      (seq_idx),
    .tx_send_o  (tx_send),
    .tx_data_o  (tx_data),
    .done_o     (seq_done)
  );

  assign busy      = (state_q != WAIT_SOF);
  assign frame_ok  = fok_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder with a simple transmitter model.
module tb_uart_cmd_responder;

  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CYC = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_ready = 1'b1;
  logic       tx_send, busy, frame_ok;
  logic [7:0] tx_data, err_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  int         sent_cnt = 0;
  int         fok_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] exp_err = 8'h00;
  int         tx_hold = 0;

  always #5 clk = ~clk;

  uart_cmd_responder #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_done   (rx_done),
    .rx_byte   (rx_byte),
    .tx_ready  (tx_ready),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .busy      (busy),
    .frame_ok  (frame_ok),
    .err_count (err_count)
  );

  // transmitter: busy for a few cycles after each send strobe
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ready <= 1'b1;
      tx_hold  <= 0;
    end else if (tx_send) begin
      tx_ready <= 1'b0;
      tx_hold  <= 3;
    end else if (tx_hold > 0) begin
      tx_hold <= tx_hold - 1;
      if (tx_hold == 1) tx_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      last_data = 8'h00;
    end else begin
      if (frame_ok) fok_cnt++;
      if (tx_send) begin
        sent_cnt++;
        checks++;
        if (tx_ready !== 1'b1) begin
          errors++;
          $display("FAIL tx_send_while_not_ready: tx_ready=%b required 1", tx_ready);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tx: got %02h required no byte", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte: got %02h required %02h", tx_data, e);
          end
        end
        last_data = tx_data;
      end else if (tx_data !== last_data) begin
        errors++;
        $display("FAIL tx_data_stable: got %02h required %02h", tx_data, last_data);
      end
    end
  end

  task automatic send_seq(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_byte = v[8*(n-1-i) +: 8];
      rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
    end
  endtask

  task automatic expect_seq(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL %s_reply_timeout: pending=%0d busy=%b required 0/0", name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tx_send !== 1'b0)    begin errors++; $display("FAIL reset_tx_send: got %b required 0", tx_send); end
    checks++; if (tx_data !== 8'h00)   begin errors++; $display("FAIL reset_tx_data: got %02h required 00", tx_data); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (frame_ok !== 1'b0)   begin errors++; $display("FAIL reset_frame_ok: got %b required 0", frame_ok); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count: got %02h required 00", err_count); end
    reset = 1'b0;
    exp_err = 8'h00;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_ping;
    fok_cnt = 0;
    expect_seq(4, 64'hA5810081);
    send_seq(4, 64'hA5010001);
    wait_idle("ping");
    checks++; if (err_count !== exp_err) begin errors++; $display("FAIL ping_err_count: got %02h required %02h", err_count, exp_err); end
    checks++; if (fok_cnt !== 1) begin errors++; $display("FAIL ping_frame_ok: got %0d pulses required 1", fok_cnt); end
  endtask

  task automatic test_bad_chk;
    fok_cnt = 0;
    expect_seq(5, 64'hA5FF0101FF);
    send_seq(4, 64'hA5010000);
    exp_err++;
    wait_idle("bad_chk");
    checks++; if (err_count !== exp_err) begin errors++; $display("FAIL bad_chk_err_count: got %02h required %02h", err_count, exp_err); end
    checks++; if (fok_cnt !== 0) begin errors++; $display("FAIL bad_chk_frame_ok: got %0d pulses required 0", fok_cnt); end
  endtask

  task automatic test_status;
    fok_cnt = 0;
    expect_seq(6, 64'hA58302010181);
    send_seq(4, 64'hA5030003);
    wait_idle("status");
    checks++; if (fok_cnt !== 1) begin errors++; $display("FAIL status_frame_ok: got %0d pulses required 1", fok_cnt); end
  endtask

  task automatic test_echo;
    expect_seq(6, 64'hA582021122B3);
    send_seq(8, 64'h005AA50202112233);
    wait_idle("echo");
    checks++; if (err_count !== exp_err) begin errors++; $display("FAIL echo_err_count: got %02h required %02h", err_count, exp_err); end
  endtask

  task automatic test_unknown_cmd;
    expect_seq(5, 64'hA5FF0103FD);
    send_seq(4, 64'hA5070007);
    exp_err++;
    wait_idle("unknown");
    checks++; if (err_count !== exp_err) begin errors++; $display("FAIL unknown_err_count: got %02h required %02h", err_count, exp_err); end
  endtask

  task automatic test_oversize;
    expect_seq(5, 64'hA5FF0102FC);
    send_seq(3, 64'hA50120);
    exp_err++;
    wait_idle("oversize");
    checks++; if (err_count !== exp_err) begin errors++; $display("FAIL oversize_err_count: got %02h required %02h", err_count, exp_err); end
  endtask

  task automatic test_back_to_back;
    fok_cnt = 0;
    expect_seq(7, 64'hA5820301020381);
    send_seq(7, 64'hA5020301020301);
    send_seq(1, 64'hA5);
    exp_err++;
    wait_idle("overrun_echo");
    expect_seq(4, 64'hA5810081);
    send_seq(4, 64'hA5010001);
    wait_idle("b2b_ping");
    checks++; if (err_count !== exp_err) begin errors++; $display("FAIL overrun_err_count: got %02h required %02h", err_count, exp_err); end
    checks++; if (fok_cnt !== 2) begin errors++; $display("FAIL b2b_frame_ok: got %0d pulses required 2", fok_cnt); end
  endtask

  task automatic test_timeout;
    int s0;
    s0 = sent_cnt;
    send_seq(2, 64'hA501);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_mid_frame: got %b required 1", busy); end
    repeat (TIMEOUT_CYC + 10) @(posedge clk);
    @(negedge clk);
    exp_err++;
    checks++; if (sent_cnt !== s0) begin errors++; $display("FAIL timeout_no_tx: got %0d sends required %0d", sent_cnt, s0); end
    checks++; if (err_count !== exp_err) begin errors++; $display("FAIL timeout_err_count: got %02h required %02h", err_count, exp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b required 0", busy); end
  endtask

  task automatic test_reset_mid_reply;
    int s0;
    int k = 0;
    expect_seq(1, 64'hA5);
    send_seq(4, 64'hA5010001);
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 200) begin
      errors++;
      $display("FAIL mid_reply_first_byte: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    s0 = sent_cnt;
    #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (tx_send !== 1'b0)    begin errors++; $display("FAIL mid_reset_tx_send: got %b required 0", tx_send); end
    checks++; if (tx_data !== 8'h00)   begin errors++; $display("FAIL mid_reset_tx_data: got %02h required 00", tx_data); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL mid_reset_busy: got %b required 0", busy); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL mid_reset_err_count: got %02h required 00", err_count); end
    checks++; if (frame_ok !== 1'b0)   begin errors++; $display("FAIL mid_reset_frame_ok: got %b required 0", frame_ok); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_err = 8'h00;
    repeat (60) @(posedge clk);
    @(negedge clk);
    checks++; if (sent_cnt !== s0) begin errors++; $display("FAIL mid_reset_no_tx: got %0d sends required %0d", sent_cnt, s0); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL mid_reset_idle_busy: got %b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_ping();
    test_bad_chk();
    test_status();
    test_echo();
    test_unknown_cmd();
    test_oversize();
    test_back_to_back();
    test_timeout();
    test_reset_mid_reply();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
